sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Parametrised successor to the fixed five-sprite display pixel generator.
- Composites NUM_LAYERS scaled sprite layers over a background frame buffer, in strict priority order, with colour-key transparency and per-layer horizontal flip.
- Latches sprite parameters once per frame, so sprites never tear mid-frame.
- Sits between vga_sync and the sram instances. It drives the ROM addresses, consumes the ROM data (1-cycle read latency) and produces the registered RGB output.

Parameters:
NUM_LAYERS, 4, number of sprite layers; layer 0 has the highest priority
SCALE_SHIFT, 1, log2 of the screen-pixel to sprite-pixel scale factor
COORD_W, 12, width of each sprite coordinate (sprite-pixel units)
SIZE_W, 8, width of each sprite width/height field
ADDR_W, 18, ROM address width
DATA_W, 12, RGB width
KEY_COLOR, 12'h0f0, transparent colour key
BG_W, 320, background width in sprite pixels

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active high
pixel_x  in  10  screen x of the next pixel
pixel_y  in  10  screen y of the next pixel
pixel_tick  in  1  pixel update strobe
video_on  in  1  visible region
frame_start  in  1  one-cycle pulse; loads the shadow layer registers
layer_x  in  NUM_LAYERS*COORD_W  packed x positions, layer i at [i*COORD_W +: COORD_W]
layer_y  in  NUM_LAYERS*COORD_W  packed y positions
layer_w  in  NUM_LAYERS*SIZE_W  sprite widths
layer_h  in  NUM_LAYERS*SIZE_W  sprite heights
layer_base  in  NUM_LAYERS*ADDR_W  ROM base address of the current frame image
layer_en  in  NUM_LAYERS  layer enable
layer_hflip  in  NUM_LAYERS  mirror horizontally
rom_addr  out  NUM_LAYERS*ADDR_W  per-layer ROM address
rom_data  in  NUM_LAYERS*DATA_W  per-layer ROM data, valid 1 clk after address
bg_addr  out  ADDR_W  background ROM address
bg_data  in  DATA_W  background data, 1-clk latency
rgb  out  DATA_W  registered pixel colour
active_layer  out  NUM_LAYERS+1  one-hot winner of the last loaded pixel; bit NUM_LAYERS = background

Behaviour:
- Reset: all shadow registers 0 (all layers disabled); rom_addr, bg_addr, rgb and active_layer are 0; pipeline valid bits are cleared.
- Shadow registers: on frame_start, all layer_* inputs are copied into the shadows. At all other times the shadows hold. Every compositing computation uses only the shadows.
- S1 (edge 1, computed from pixel_x/pixel_y):
  - Let X = shadow x << SCALE_SHIFT and Y = shadow y << SCALE_SHIFT.
  - hit_i = en_i && pixel_x >= X && pixel_x < X + (w_i << SCALE_SHIFT) && pixel_y >= Y && pixel_y < Y + (h_i << SCALE_SHIFT).
  - Compare at COORD_W+2 bits with no wrap. A sprite partly off the right or bottom edge is clipped, never wrapped.
  - col = (pixel_x - X) >> SCALE_SHIFT. If hflip_i, col = w_i - 1 - col.
  - row = (pixel_y - Y) >> SCALE_SHIFT.
  - rom_addr_i = base_i + row*w_i + col on a hit, else 0.
  - bg_addr = (pixel_y >> SCALE_SHIFT)*BG_W + (pixel_x >> SCALE_SHIFT).
  - hit_i, video_on and pixel_tick are registered alongside the addresses.
- S2 (edge 2): the ROM delivers data.
  - The hit, video_on and tick flags are delayed one more stage to align with the data.
- S3 (edge 3), only when the S2-aligned tick is 1:
  - Winner = lowest i with hit_i && rom_data_i != KEY_COLOR; otherwise the background.
  - rgb = winner data, or 0 if the aligned video_on is 0.
  - active_layer = one-hot winner (all zeros when video_on is 0).
  - When the aligned tick is 0, rgb and active_layer hold.
- Latency: 3 clk from pixel_x/pixel_y to rgb. The pipeline advances every clk regardless of pixel_tick.
- A missed layer's data is ignored even if non-key. Background data equal to KEY_COLOR is still output.
- If frame_start coincides with a pixel, the shadow update is visible from the next cycle's S1 onward.
- w_i = 0 or h_i = 0 means the layer never hits.
- Reset mid-line: the output is 0 until three ticks after reset is released.

Optional Feature:
COLLISION_DETECT_EN
- Defined: adds output `collision` (NUM_LAYERS*NUM_LAYERS bits, bit [i*NUM_LAYERS+j] for i<j, others 0).
  - At S3 on each tick with video_on, any pair i<j both hit and both non-key sets its bit, regardless of priority.
  - Bits are sticky and clear on frame_start and on reset.
  - When frame_start and a set condition occur in the same cycle, the clear wins.
- Undefined: no port and no logic.

Test Plan:
- Reset, then one frame with all layers disabled and bg_data = 12'h123 → rgb = 12'h123 and active_layer = 5'b10000, 3 clk after each pixel.
- Layer 0 at x=10,y=10, w=4, h=4, base=100, scale 1 → pixel (20,20) gives rom_addr0 = 100; pixel (27,21) gives 103; pixel (28,20) gives no hit and rom_addr0 = 0.
- Layer 0 with hflip at the same placement → pixel (20,20) gives rom_addr0 = 103.
- Layers 0 and 1 overlap; layer 0 data = KEY_COLOR, layer 1 data = 12'hF00 → rgb = 12'hF00 and active_layer = 00010. With layer 0 data = 12'h00F → rgb = 12'h00F.
- Change layer_x mid-frame without frame_start → no output change. After a frame_start pulse → the new position is used.
- video_on = 0 with a hit → rgb = 0. With COLLISION_DETECT_EN, opaque overlap of layers 0 and 2 → bit 2 set and held until frame_start.

Source files
------------

// File: rtl/sprite_compositor.sv
// ============================================================================
// Module  : sprite_compositor
// Brief   : Priority compositor for NUM_LAYERS scaled sprites over a background.
//           Optional macro COLLISION_DETECT_EN adds sticky pairwise collisions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_compositor #(
    parameter int                NUM_LAYERS  = 4,
    parameter int                SCALE_SHIFT = 1,
    parameter int                COORD_W     = 12,
    parameter int                SIZE_W      = 8,
    parameter int                ADDR_W      = 18,
    parameter int                DATA_W      = 12,
    parameter logic [DATA_W-1:0] KEY_COLOR   = 12'h0f0,
    parameter int                BG_W        = 320
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [9:0]                     pixel_x,
    input  logic [9:0]                     pixel_y,
    input  logic                           pixel_tick,
    input  logic                           video_on,
    input  logic                           frame_start,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_y,
    input  logic [NUM_LAYERS*SIZE_W-1:0]   layer_w,
    input  logic [NUM_LAYERS*SIZE_W-1:0]   layer_h,
    input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_base,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS-1:0]          layer_hflip,
    output logic [NUM_LAYERS*ADDR_W-1:0]   rom_addr,
    input  logic [NUM_LAYERS*DATA_W-1:0]   rom_data,
    output logic [ADDR_W-1:0]              bg_addr,
    input  logic [DATA_W-1:0]              bg_data,
    output logic [DATA_W-1:0]              rgb,
    output logic [NUM_LAYERS:0]            active_layer
`ifdef COLLISION_DETECT_EN
    ,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] collision
`endif
);

    localparam int CW = COORD_W + 2;

    logic [NUM_LAYERS*COORD_W-1:0] sx_q, sy_q;
    logic [NUM_LAYERS*SIZE_W-1:0]  sw_q, sh_q;
    logic [NUM_LAYERS*ADDR_W-1:0]  sbase_q;
    logic [NUM_LAYERS-1:0]         sen_q, sflip_q;

    // Shadow copies make every sprite parameter change take effect on a frame boundary only.
    always_ff @(posedge clk) begin
        if (reset) begin
            sx_q    <= '0;
            sy_q    <= '0;
            sw_q    <= '0;
            sh_q    <= '0;
            sbase_q <= '0;
            sen_q   <= '0;
            sflip_q <= '0;
        end else if (frame_start) begin
            sx_q    <= layer_x;
            sy_q    <= layer_y;
            sw_q    <= layer_w;
            sh_q    <= layer_h;
            sbase_q <= layer_base;
            sen_q   <= layer_en;
            sflip_q <= layer_hflip;
        end
    end

    logic [CW-1:0]                w_px, w_py;
    logic [NUM_LAYERS-1:0]        w_hit;
    logic [NUM_LAYERS*ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0]            w_bg_addr;

    assign w_px = {{(CW-10){1'b0}}, pixel_x};
    assign w_py = {{(CW-10){1'b0}}, pixel_y};

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        logic [CW-1:0]     w_x0, w_y0, w_xe, w_ye, w_dx, w_dy;
        logic [SIZE_W-1:0] w_w, w_h, w_col, w_colf, w_row;

        assign w_w  = sw_q[i*SIZE_W +: SIZE_W];
        assign w_h  = sh_q[i*SIZE_W +: SIZE_W];
        assign w_x0 = {2'b00, sx_q[i*COORD_W +: COORD_W]} << SCALE_SHIFT;
        assign w_y0 = {2'b00, sy_q[i*COORD_W +: COORD_W]} << SCALE_SHIFT;
        assign w_xe = w_x0 + ({{(CW-SIZE_W){1'b0}}, w_w} << SCALE_SHIFT);
        assign w_ye = w_y0 + ({{(CW-SIZE_W){1'b0}}, w_h} << SCALE_SHIFT);

        // Zero width/height collapses the window so the layer can never hit.
        assign w_hit[i] = sen_q[i] && (w_px >= w_x0) && (w_px < w_xe)
                                   && (w_py >= w_y0) && (w_py < w_ye);

        assign w_dx   = w_px - w_x0;
        assign w_dy   = w_py - w_y0;
        assign w_col  = SIZE_W'(w_dx >> SCALE_SHIFT);
        assign w_row  = SIZE_W'(w_dy >> SCALE_SHIFT);
        assign w_colf = sflip_q[i] ? (w_w - SIZE_W'(1) - w_col) : w_col;

        assign w_addr[i*ADDR_W +: ADDR_W] = w_hit[i]
            ? (sbase_q[i*ADDR_W +: ADDR_W] + ADDR_W'(w_row) * ADDR_W'(w_w) + ADDR_W'(w_colf))
            : '0;
    end

    assign w_bg_addr = ADDR_W'(pixel_y >> SCALE_SHIFT) * ADDR_W'(BG_W)
                     + ADDR_W'(pixel_x >> SCALE_SHIFT);

    logic [NUM_LAYERS*ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0]            bg_addr_q;
    logic [NUM_LAYERS-1:0]        hit1_q, hit2_q;
    logic                         von1_q, von2_q, tick1_q, tick2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            bg_addr_q  <= '0;
            hit1_q     <= '0;
            hit2_q     <= '0;
            von1_q     <= 1'b0;
            von2_q     <= 1'b0;
            tick1_q    <= 1'b0;
            tick2_q    <= 1'b0;
        end else begin
            rom_addr_q <= w_addr;
            bg_addr_q  <= w_bg_addr;
            hit1_q     <= w_hit;
            von1_q     <= video_on;
            tick1_q    <= pixel_tick;
            hit2_q     <= hit1_q;
            von2_q     <= von1_q;
            tick2_q    <= tick1_q;
        end
    end

    logic [NUM_LAYERS-1:0] w_opaque;
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_opaque
        assign w_opaque[i] = rom_data[i*DATA_W +: DATA_W] != KEY_COLOR;
    end

    logic [DATA_W-1:0]   rgb_q, rgb_d;
    logic [NUM_LAYERS:0] act_q, act_d;

    always_comb begin
        logic                found;
        logic [DATA_W-1:0]   sel_data;
        logic [NUM_LAYERS:0] sel_hot;
        found               = 1'b0;
        sel_data            = bg_data;
        sel_hot             = '0;
        sel_hot[NUM_LAYERS] = 1'b1;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (!found && hit2_q[i] && w_opaque[i]) begin
                found      = 1'b1;
                sel_data   = rom_data[i*DATA_W +: DATA_W];
                sel_hot    = '0;
                sel_hot[i] = 1'b1;
            end
        end
        rgb_d = rgb_q;
        act_d = act_q;
        if (tick2_q) begin
            rgb_d = von2_q ? sel_data : '0;
            act_d = von2_q ? sel_hot  : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
            act_q <= '0;
        end else begin
            rgb_q <= rgb_d;
            act_q <= act_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign bg_addr      = bg_addr_q;
    assign rgb          = rgb_q;
    assign active_layer = act_q;

`ifdef COLLISION_DETECT_EN
    logic [NUM_LAYERS*NUM_LAYERS-1:0] w_pair, coll_q;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_ci
        for (genvar j = 0; j < NUM_LAYERS; j++) begin : g_cj
            if (i < j) begin : g_pair
                assign w_pair[i*NUM_LAYERS+j] = hit2_q[i] && hit2_q[j] && w_opaque[i] && w_opaque[j];
            end else begin : g_nopair
                assign w_pair[i*NUM_LAYERS+j] = 1'b0;
            end
        end
    end

    // Clear on frame_start takes priority over a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            coll_q <= '0;
        end else if (tick2_q && von2_q) begin
            coll_q <= coll_q | w_pair;
        end
    end

    assign collision = coll_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// ============================================================================
// Module  : tb_sprite_compositor
// Brief   : Directed self-checking bench for sprite_compositor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_compositor;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    pixel_x, pixel_y;
    logic          pixel_tick, video_on, frame_start;
    logic [NL*12-1:0] layer_x, layer_y;
    logic [NL*8-1:0]  layer_w, layer_h;
    logic [NL*18-1:0] layer_base;
    logic [NL-1:0]    layer_en, layer_hflip;
    logic [NL*18-1:0] rom_addr;
    logic [NL*12-1:0] rom_data;
    logic [17:0]      bg_addr;
    logic [11:0]      bg_data;
    logic [11:0]      rgb;
    logic [NL:0]      active_layer;
`ifdef COLLISION_DETECT_EN
    logic [NL*NL-1:0] collision;
`endif

    logic [11:0] rom_val [NL];
    logic [11:0] bg_val;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] a0, bga;
    logic [11:0] c;
    logic [4:0]  act;

    sprite_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_tick   (pixel_tick),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .layer_x      (layer_x),
        .layer_y      (layer_y),
        .layer_w      (layer_w),
        .layer_h      (layer_h),
        .layer_base   (layer_base),
        .layer_en     (layer_en),
        .layer_hflip  (layer_hflip),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .bg_addr      (bg_addr),
        .bg_data      (bg_data),
        .rgb          (rgb),
        .active_layer (active_layer)
`ifdef COLLISION_DETECT_EN
        ,
        .collision    (collision)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: one-cycle read latency, contents fixed per layer.
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) rom_data[i*12 +: 12] <= rom_val[i];
        bg_data <= bg_val;
    end

    task automatic set_layer(input int i, input [11:0] x, input [11:0] y, input [7:0] w,
                             input [7:0] h, input [17:0] base, input logic en, input logic flip);
        layer_x[i*12 +: 12]    = x;
        layer_y[i*12 +: 12]    = y;
        layer_w[i*8 +: 8]      = w;
        layer_h[i*8 +: 8]      = h;
        layer_base[i*18 +: 18] = base;
        layer_en[i]            = en;
        layer_hflip[i]         = flip;
    endtask

    task automatic load_frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    // One ticked pixel; captures S1 addresses after edge 1 and the output after edge 3.
    task automatic run_pixel(input [9:0] x, input [9:0] y, input logic von);
        @(negedge clk);
        pixel_x = x; pixel_y = y; video_on = von; pixel_tick = 1'b1;
        @(posedge clk); #1;
        a0  = rom_addr[17:0];
        bga = bg_addr;
        @(negedge clk);
        pixel_tick = 1'b0; pixel_x = '0; pixel_y = '0;
        @(posedge clk);
        @(posedge clk); #1;
        c   = rgb;
        act = active_layer;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want %h", rgb, 12'h000); end
        n_checks++;
        if (active_layer !== 5'b00000) begin n_fail++; $display("FAIL reset_active: got %b want %b", active_layer, 5'b00000); end
        n_checks++;
        if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        n_checks++;
        if (bg_addr !== 18'd0) begin n_fail++; $display("FAIL reset_bg_addr: got %0d want 0", bg_addr); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_background();
        bg_val = 12'h123;
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (bga !== 18'd3210) begin n_fail++; $display("FAIL bg_addr: got %0d want %0d", bga, 3210); end
        n_checks++;
        if (c !== 12'h123) begin n_fail++; $display("FAIL bg_rgb: got %h want %h", c, 12'h123); end
        n_checks++;
        if (act !== 5'b10000) begin n_fail++; $display("FAIL bg_active: got %b want %b", act, 5'b10000); end
        n_checks++;
        if (a0 !== 18'd0) begin n_fail++; $display("FAIL bg_rom_addr0: got %0d want 0", a0); end
    endtask

    task automatic test_address();
        set_layer(0, 12'd10, 12'd10, 8'd4, 8'd4, 18'd100, 1'b1, 1'b0);
        load_frame();
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (a0 !== 18'd100) begin n_fail++; $display("FAIL addr_origin: got %0d want %0d", a0, 100); end
        run_pixel(10'd27, 10'd21, 1'b1);
        n_checks++;
        if (a0 !== 18'd103) begin n_fail++; $display("FAIL addr_lastcol: got %0d want %0d", a0, 103); end
        run_pixel(10'd28, 10'd20, 1'b1);
        n_checks++;
        if (a0 !== 18'd0) begin n_fail++; $display("FAIL addr_right_edge: got %0d want 0", a0); end
        run_pixel(10'd21, 10'd27, 1'b1);
        n_checks++;
        if (a0 !== 18'd112) begin n_fail++; $display("FAIL addr_lastrow: got %0d want %0d", a0, 112); end
        run_pixel(10'd20, 10'd28, 1'b1);
        n_checks++;
        if (a0 !== 18'd0) begin n_fail++; $display("FAIL addr_bottom_edge: got %0d want 0", a0); end
    endtask

    task automatic test_hflip();
        set_layer(0, 12'd10, 12'd10, 8'd4, 8'd4, 18'd100, 1'b1, 1'b1);
        load_frame();
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (a0 !== 18'd103) begin n_fail++; $display("FAIL hflip_addr: got %0d want %0d", a0, 103); end
        set_layer(0, 12'd10, 12'd10, 8'd4, 8'd4, 18'd100, 1'b1, 1'b0);
        load_frame();
    endtask

    task automatic test_priority();
        set_layer(1, 12'd10, 12'd10, 8'd4, 8'd4, 18'd200, 1'b1, 1'b0);
        load_frame();
        rom_val[0] = 12'h0f0;
        rom_val[1] = 12'hf00;
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (c !== 12'hf00) begin n_fail++; $display("FAIL prio_key_rgb: got %h want %h", c, 12'hf00); end
        n_checks++;
        if (act !== 5'b00010) begin n_fail++; $display("FAIL prio_key_active: got %b want %b", act, 5'b00010); end
        rom_val[0] = 12'h00f;
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (c !== 12'h00f) begin n_fail++; $display("FAIL prio_top_rgb: got %h want %h", c, 12'h00f); end
        n_checks++;
        if (act !== 5'b00001) begin n_fail++; $display("FAIL prio_top_active: got %b want %b", act, 5'b00001); end
        run_pixel(10'd40, 10'd40, 1'b1);
        n_checks++;
        if (c !== 12'h123) begin n_fail++; $display("FAIL miss_ignored_rgb: got %h want %h", c, 12'h123); end
        n_checks++;
        if (act !== 5'b10000) begin n_fail++; $display("FAIL miss_ignored_active: got %b want %b", act, 5'b10000); end
    endtask

    task automatic test_shadow();
        layer_x[11:0] = 12'd50;
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (c !== 12'h00f) begin n_fail++; $display("FAIL shadow_hold_rgb: got %h want %h", c, 12'h00f); end
        load_frame();
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (c !== 12'hf00) begin n_fail++; $display("FAIL shadow_load_rgb: got %h want %h", c, 12'hf00); end
        n_checks++;
        if (act !== 5'b00010) begin n_fail++; $display("FAIL shadow_load_active: got %b want %b", act, 5'b00010); end
        run_pixel(10'd100, 10'd20, 1'b1);
        n_checks++;
        if (a0 !== 18'd100) begin n_fail++; $display("FAIL shadow_new_addr: got %0d want %0d", a0, 100); end
        n_checks++;
        if (c !== 12'h00f) begin n_fail++; $display("FAIL shadow_new_rgb: got %h want %h", c, 12'h00f); end
        set_layer(0, 12'd10, 12'd10, 8'd4, 8'd4, 18'd100, 1'b1, 1'b0);
        load_frame();
    endtask

    task automatic test_video_off();
        run_pixel(10'd20, 10'd20, 1'b0);
        n_checks++;
        if (c !== 12'h000) begin n_fail++; $display("FAIL voff_rgb: got %h want %h", c, 12'h000); end
        n_checks++;
        if (act !== 5'b00000) begin n_fail++; $display("FAIL voff_active: got %b want %b", act, 5'b00000); end
    endtask

    task automatic test_tick_hold();
        @(negedge clk);
        pixel_x = 10'd20; pixel_y = 10'd20; video_on = 1'b1; pixel_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL tick_hold_rgb: got %h want %h", rgb, 12'h000); end
        n_checks++;
        if (active_layer !== 5'b00000) begin n_fail++; $display("FAIL tick_hold_active: got %b want %b", active_layer, 5'b00000); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pixel_x = 10'd20; pixel_y = 10'd20; video_on = 1'b1; pixel_tick = 1'b1;
        @(negedge clk);
        pixel_x = 10'd60; pixel_y = 10'd60;
        @(negedge clk);
        pixel_tick = 1'b0;
        #1;
        n_checks++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL b2b_latency_early: got %h want %h", rgb, 12'h000); end
        @(posedge clk); #1;
        n_checks++;
        if (rgb !== 12'h00f) begin n_fail++; $display("FAIL b2b_first: got %h want %h", rgb, 12'h00f); end
        @(posedge clk); #1;
        n_checks++;
        if (rgb !== 12'h123) begin n_fail++; $display("FAIL b2b_second: got %h want %h", rgb, 12'h123); end
    endtask

    task automatic test_zero_width();
        set_layer(0, 12'd10, 12'd10, 8'd0, 8'd4, 18'd100, 1'b1, 1'b0);
        set_layer(1, 12'd0, 12'd0, 8'd0, 8'd0, 18'd0, 1'b0, 1'b0);
        load_frame();
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (a0 !== 18'd0) begin n_fail++; $display("FAIL zero_w_addr: got %0d want 0", a0); end
        n_checks++;
        if (act !== 5'b10000) begin n_fail++; $display("FAIL zero_w_active: got %b want %b", act, 5'b10000); end
    endtask

`ifdef COLLISION_DETECT_EN
    task automatic test_collision();
        set_layer(0, 12'd10, 12'd10, 8'd4, 8'd4, 18'd100, 1'b1, 1'b0);
        set_layer(2, 12'd10, 12'd10, 8'd4, 8'd4, 18'd300, 1'b1, 1'b0);
        rom_val[2] = 12'h0aa;
        load_frame();
        run_pixel(10'd20, 10'd20, 1'b1);
        n_checks++;
        if (collision !== 16'h0004) begin n_fail++; $display("FAIL coll_set: got %h want %h", collision, 16'h0004); end
        run_pixel(10'd60, 10'd60, 1'b1);
        n_checks++;
        if (collision !== 16'h0004) begin n_fail++; $display("FAIL coll_sticky: got %h want %h", collision, 16'h0004); end
        load_frame();
        #1;
        n_checks++;
        if (collision !== 16'h0000) begin n_fail++; $display("FAIL coll_clear: got %h want %h", collision, 16'h0000); end
    endtask
`endif

    initial begin
        reset = 1'b1; pixel_x = '0; pixel_y = '0; pixel_tick = 1'b0; video_on = 1'b0;
        frame_start = 1'b0; layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
        layer_base = '0; layer_en = '0; layer_hflip = '0; bg_val = '0;
        for (int i = 0; i < NL; i++) rom_val[i] = 12'h0f0;
        test_reset();
        test_background();
        test_address();
        test_hflip();
        test_priority();
        test_shadow();
        test_video_off();
        test_tick_hold();
        test_back_to_back();
        test_zero_width();
`ifdef COLLISION_DETECT_EN
        test_collision();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
